// File: rtl/risc_controller.sv
// VeriRISC sequencing controller: 8-phase instruction sequencer with sticky halt,
// decoding phase/opcode/zero into datapath load and enable strobes.
module risc_controller #(
    parameter int unsigned OPW = 3,
    parameter int unsigned PHW = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic [PHW-1:0] phase,
    output logic           sel,
    output logic           rd,
    output logic           ld_ir,
    output logic           inc_pc,
    output logic           halt,
    output logic           ld_pc,
    output logic           data_e,
    output logic           ld_ac,
    output logic           wr
);

    localparam logic [OPW-1:0] OP_HLT = OPW'(0);
    localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_AND = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_LDA = OPW'(5);
    localparam logic [OPW-1:0] OP_STO = OPW'(6);
    localparam logic [OPW-1:0] OP_JMP = OPW'(7);

    typedef enum logic [PHW-1:0] {
        INST_ADDR,
        INST_FETCH,
        INST_LOAD,
        IDLE,
        OP_ADDR,
        OP_FETCH,
        ALU_OP,
        STORE
    } phase_t;

    phase_t r_phase;
    phase_t w_phase_nxt;
    logic   r_halted;
    logic   w_halted_nxt;
    logic   w_aluop;
    logic   w_is_hlt;
    logic   w_is_skz;
    logic   w_is_sto;
    logic   w_is_jmp;

    assign w_aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
    assign w_is_hlt = (opcode == OP_HLT);
    assign w_is_skz = (opcode == OP_SKZ);
    assign w_is_sto = (opcode == OP_STO);
    assign w_is_jmp = (opcode == OP_JMP);
    assign phase    = r_phase;

    // State register: phase counter and sticky halted flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_phase_nxt  = r_phase;
        w_halted_nxt = r_halted;
        sel          = 1'b0;
        rd           = 1'b0;
        ld_ir        = 1'b0;
        inc_pc       = 1'b0;
        halt         = 1'b0;
        ld_pc        = 1'b0;
        data_e       = 1'b0;
        ld_ac        = 1'b0;
        wr           = 1'b0;

        if (!r_halted && enable) begin
            // A HLT freezes the sequencer in OP_ADDR instead of advancing
            if (r_phase == OP_ADDR && w_is_hlt) begin
                w_halted_nxt = 1'b1;
            end else begin
                w_phase_nxt = phase_t'(r_phase + PHW'(1));
            end
        end

        if (r_halted) begin
            halt = 1'b1;
        end else begin
            case (r_phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = w_is_hlt;
                end
                OP_FETCH: begin
                    rd = w_aluop;
                end
                ALU_OP: begin
                    rd     = w_aluop;
                    inc_pc = w_is_skz && zero;
                    ld_pc  = w_is_jmp;
                    data_e = w_is_sto;
                end
                STORE: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    ld_pc  = w_is_jmp;
                    wr     = w_is_sto;
                    data_e = w_is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- Sequencing controller for the VeriRISC datapath.
- Holds a 3-bit phase counter that steps each instruction through 8 fixed phases.
- Decodes the current phase, the opcode and the accumulator zero flag into load/enable strobes. These strobes drive the enable input of the downstream register instances (instruction register, accumulator) and of the PC, memory and bus driver.
- Sits directly upstream of the register stage; its ld_ir/ld_ac outputs connect straight to register enable pins.

Parameters:
- OPW, 3, opcode width. Fixed encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- PHW, 3, phase counter width (8 phases).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  phase advance enable; 0 freezes the phase and holds all outputs steady.
- opcode  input  OPW  opcode field from the instruction register output.
- zero  input  1  accumulator-is-zero flag.
- phase  output  PHW  current phase, for debug and bench use.
- sel  output  1  address mux: 1 selects the PC, 0 selects the IR address field.
- rd  output  1  memory read.
- ld_ir  output  1  instruction register load enable.
- inc_pc  output  1  PC increment.
- halt  output  1  halted indication.
- ld_pc  output  1  PC load (jump).
- data_e  output  1  accumulator drives the data bus.
- ld_ac  output  1  accumulator load enable.
- wr  output  1  memory write.

Behaviour:
- Registered state is the phase counter plus a sticky halted flag. All other outputs are combinational from the current phase, opcode, zero and halted. Decoding adds no latency.
- Reset (reset=0, asynchronous): phase=0 and halted=0 immediately. Outputs then show the phase-0 decode: sel=1, all other strobes 0.
- Phase advance, on a rising edge with reset=1, enable=1 and halted=0: phase <= phase+1. Phase 7 wraps to 0.
- enable=0: phase and halted hold; outputs stay at the decode of the held state.
- Define ALUOP = opcode in {ADD, AND, XOR, LDA}. Per-phase decode (unlisted outputs are 0):
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, rd=1.
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - 3 IDLE: sel=1, rd=1, ld_ir=1.
  - 4 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- Halt:
  - On an advancing edge in phase 4 with opcode==HLT: halted<=1 and phase holds at 4.
  - While halted: halt=1 and every other strobe is 0. This includes inc_pc and sel, so the PC does not move.
  - Phase stays at 4 regardless of enable or opcode changes.
  - Only reset clears halted.
- In phase 4 before the halting edge, inc_pc=1 and halt=1 together, so the PC has advanced past the HLT instruction.
- opcode and zero are sampled combinationally every cycle. They must be stable from phase 2 onward; the controller performs no internal latching.
- Reset mid-instruction (any phase, any time) returns to phase 0 with halted=0. No strobe glitches other than the combinational settle to the phase-0 decode.
- Outputs never contain X/Z once reset has been applied.

Test Plan:
- Reset: reset=0 at phase 5 mid-cycle → phase=0, sel=1, rd=ld_ir=inc_pc=halt=ld_pc=data_e=ld_ac=wr=0, with no clock edge needed.
- LDA walk: opcode=5, zero=0, enable=1, 8 edges from phase 0 → strobe sequence matches the table. ld_ir=1 in phases 2–3 only; rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; phase returns to 0.
- SKZ: opcode=1 with zero=1 → inc_pc=1 in phase 6. Repeat with zero=0 → inc_pc=0 in phase 6. inc_pc=1 in phase 4 in both runs.
- STO/JMP: opcode=6 → data_e=1 in phases 6–7, wr=1 only in phase 7, rd=0 in phases 5–7. opcode=7 → ld_pc=1 in phases 6–7, wr=data_e=0.
- Enable stall: enable=0 for 3 edges at phase 3 → phase stays 3 and ld_ir stays 1. Restore enable=1 → next edge gives phase=4.
- Halt: opcode=0 and reach phase 4 → halt=1, inc_pc=1. After the next edge: phase=4, halt=1, inc_pc=0, sel=0. Ten more edges with opcode=2 → no change. reset=0 → phase=0, halt=0.
